// File: rtl/instruction_fetch_stage_if.sv
// rtl/instruction_fetch_stage_if.sv - instruction memory request/response bus
// master is the fetch stage, slave is the instruction memory.
interface instruction_fetch_stage_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC owner, in-order imem fetch, instruction FIFO, redirect flush
// Outstanding requests plus buffered words never exceed DEPTH, so the FIFO cannot overflow.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_stage_if.master  imem,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [31:0]                branch_target,
  output logic [31:0]                instruction,
  output logic [31:0]                pc,
  output logic                       valid
);
  localparam int          PW         = $clog2(DEPTH);
  localparam int          CW         = PW + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_word [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [PW-1:0] fifo_rd;
  logic [PW-1:0] fifo_wr;
  logic [CW-1:0] fifo_count;
  logic [31:0]   infl_pc   [DEPTH];
  logic [PW-1:0] infl_rd;
  logic [PW-1:0] infl_wr;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_keep;
  logic          pop;
  logic [CW:0]   credit_used;
  logic [CW-1:0] outstanding_next;

  assign credit_used         = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem.imem_req_valid = rst && !branch_taken && (credit_used < CREDIT_MAX);
  assign imem.imem_req_addr  = fetch_pc;

  assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
  // A response with nothing outstanding is illegal and simply ignored.
  assign rsp_fire = imem.imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_fire && !branch_taken && (discard == '0);
  assign pop      = valid && !stall;

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);

  assign valid       = (fifo_count != '0);
  assign instruction = valid ? fifo_word[fifo_rd] : NOP;
  assign pc          = valid ? fifo_pc[fifo_rd]   : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      fifo_count  <= '0;
      infl_rd     <= '0;
      infl_wr     <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (req_fire) begin
        infl_wr  <= infl_wr + PW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (rsp_fire) begin
        infl_rd <= infl_rd + PW'(1);
      end
      if (branch_taken) begin
        // Everything still in flight belongs to the old path.
        fetch_pc   <= branch_target & 32'hFFFF_FFFC;
        discard    <= outstanding_next;
        fifo_rd    <= '0;
        fifo_wr    <= '0;
        fifo_count <= '0;
      end else begin
        if (rsp_fire && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        if (rsp_keep) begin
          fifo_wr <= fifo_wr + PW'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + PW'(1);
        end
        fifo_count <= fifo_count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      infl_pc[infl_wr] <= fetch_pc;
    end
    if (rsp_keep) begin
      fifo_word[fifo_wr] <= imem.imem_rsp_data;
      fifo_pc[fifo_wr]   <= infl_pc[infl_rd];
    end
  end
endmodule
